// File: rtl/pio_unit.sv
// pio_unit: NUM_SM JMP/SET state machines sharing a 32-word program memory and driving a 32-bit GPIO bank.
// Define PIO_READBACK_EN to make actions 4 (X) and 8 (pc) load dout; otherwise dout is tied to 0.
module pio_unit #(
    parameter int NUM_SM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  action,
    input  logic [4:0]  index,
    input  logic [1:0]  mindex,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_dir
);
    logic [15:0] mem [32];
    logic [15:0] inst [NUM_SM];
    logic [4:0]  pc [NUM_SM], pc_n [NUM_SM], dly [NUM_SM], dly_n [NUM_SM];
    logic [4:0]  wrap_top [NUM_SM], wrap_bottom [NUM_SM], set_base [NUM_SM], jmp_pin [NUM_SM];
    logic [2:0]  set_count [NUM_SM], dst [NUM_SM];
    logic [31:0] x [NUM_SM], x_n [NUM_SM], y [NUM_SM], y_n [NUM_SM];
    logic [24:0] acc [NUM_SM], acc_n [NUM_SM], sum [NUM_SM];
    logic [23:0] div [NUM_SM], lim [NUM_SM];
    logic [7:0]  conds [NUM_SM], dat [NUM_SM];
    logic [NUM_SM-1:0] en, tick, run, is_jmp, is_set, taken;
    logic [31:0] out_n, dir_n;
    logic        unused_din;

    assign unused_din = &din[31:24];

    // SMs are applied in ascending order so a higher-numbered SM overrides a lower one on the same pin.
    always_comb begin
        out_n = gpio_out;
        dir_n = gpio_dir;
        for (int s = 0; s < NUM_SM; s++) begin
            inst[s] = mem[pc[s]];
            lim[s] = div[s] < 24'h100 ? 24'h100 : div[s];
            sum[s] = acc[s] + 25'h100;
            tick[s] = en[s] && sum[s] >= {1'b0, lim[s]};
            acc_n[s] = !en[s] ? acc[s] : tick[s] ? sum[s] - {1'b0, lim[s]} : sum[s];
            run[s] = tick[s] && dly[s] == 5'd0;
            dst[s] = inst[s][7:5];
            dat[s] = {3'b0, inst[s][4:0]};
            is_jmp[s] = run[s] && inst[s][15:13] == 3'b000;
            is_set[s] = run[s] && inst[s][15:13] == 3'b111;
            conds[s] = {1'b0, gpio_in[jmp_pin[s]], x[s] != y[s], y[s] != 0, y[s] == 0, x[s] != 0, x[s] == 0, 1'b1};
            taken[s] = is_jmp[s] && conds[s][dst[s]];
            dly_n[s] = !tick[s] ? dly[s] : run[s] ? inst[s][12:8] : dly[s] - 5'd1;
            pc_n[s] = taken[s] ? inst[s][4:0] : !run[s] ? pc[s] :
                      pc[s] == wrap_top[s] ? wrap_bottom[s] : pc[s] + 5'd1;
            x_n[s] = is_jmp[s] && dst[s] == 3'b010 ? x[s] - 32'd1 :
                     is_set[s] && dst[s] == 3'b001 ? 32'(inst[s][4:0]) : x[s];
            y_n[s] = is_jmp[s] && dst[s] == 3'b100 ? y[s] - 32'd1 :
                     is_set[s] && dst[s] == 3'b010 ? 32'(inst[s][4:0]) : y[s];
            for (int i = 0; i < 7; i++) begin
                if (is_set[s] && 3'(i) < set_count[s] && dst[s] == 3'b000)
                    out_n[set_base[s] + 5'(i)] = dat[s][i];
                if (is_set[s] && 3'(i) < set_count[s] && dst[s] == 3'b100)
                    dir_n[set_base[s] + 5'(i)] = dat[s][i];
            end
        end
    end

    // Program memory survives reset; a same-cycle fetch sees the old word.
    always_ff @(posedge clk)
        if (reset && action == 4'd1) mem[index] <= din[15:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out <= '0;
            gpio_dir <= '0;
            en <= '0;
            for (int s = 0; s < NUM_SM; s++) begin
                pc[s] <= '0;
                x[s] <= '0;
                y[s] <= '0;
                dly[s] <= '0;
                acc[s] <= '0;
                wrap_top[s] <= 5'd31;
                wrap_bottom[s] <= '0;
                div[s] <= 24'h100;
                set_base[s] <= '0;
                set_count[s] <= '0;
                jmp_pin[s] <= '0;
            end
        end else begin
            gpio_out <= out_n;
            gpio_dir <= dir_n;
            for (int s = 0; s < NUM_SM; s++) begin
                pc[s] <= pc_n[s];
                x[s] <= x_n[s];
                y[s] <= y_n[s];
                dly[s] <= dly_n[s];
                acc[s] <= acc_n[s];
                if (action == 4'd6) begin
                    en[s] <= din[s];
                    if (din[s] && !en[s]) begin
                        acc[s] <= '0;
                        dly[s] <= '0;
                    end
                end
                if (32'(mindex) == s) begin
                    if (action == 4'd2) wrap_top[s] <= din[4:0];
                    if (action == 4'd3) wrap_bottom[s] <= din[4:0];
                    if (action == 4'd5) begin
                        set_count[s] <= din[2:0];
                        set_base[s] <= din[9:5];
                        jmp_pin[s] <= din[14:10];
                    end
                    if (action == 4'd7) div[s] <= din[23:0];
                end
            end
        end
    end

`ifdef PIO_READBACK_EN
    always_ff @(posedge clk) begin
        if (!reset) dout <= '0;
        else if (32'(mindex) < NUM_SM && action == 4'd4) dout <= x[mindex];
        else if (32'(mindex) < NUM_SM && action == 4'd8) dout <= {27'b0, pc[mindex]};
    end
`else
    assign dout = '0;
`endif
endmodule

// File: tb/tb_pio_unit.sv
// tb_pio_unit: scoreboard bench for pio_unit; expected {gpio_dir, gpio_out} per cycle are queued, then popped at negedge.
module tb_pio_unit;
`ifdef PIO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  action = '0;
    logic [4:0]  index = '0;
    logic [1:0]  mindex = '0;
    logic [31:0] din = '0;
    logic [31:0] gpio_in = '0;
    logic [31:0] dout, gpio_out, gpio_dir;
    logic [63:0] exp_q [$];
    bit          mon = 1'b0;
    string       tname = "init";
    int          checks = 0;
    int          passed = 0;

    pio_unit dut (
        .clk(clk), .reset(reset), .action(action), .index(index), .mindex(mindex),
        .din(din), .dout(dout), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    always @(negedge clk)
        if (mon && exp_q.size() > 0) check(tname, {gpio_dir, gpio_out}, exp_q.pop_front());

    task automatic cmd(input logic [3:0] a, input logic [4:0] i, input logic [1:0] m, input logic [31:0] d);
        action = a;
        index = i;
        mindex = m;
        din = d;
        @(posedge clk);
        #1 action = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step(input int n);
        mon = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        #1 mon = 1'b0;
        check({tname, "_drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Square-wave program state after n ticks: pindirs set on tick 1, then 2 ticks high / 2 low from tick 2.
    function automatic logic [63:0] sq(input int n);
        logic hi;
        hi = ((n - 2) / 2) % 2 == 0;
        return n == 0 ? 64'd0 : n == 1 ? {32'd1, 32'd0} : {32'd1, 31'd0, hi};
    endfunction

    initial begin
        gpio_in = 32'hFFFF_FFDF;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_out", 64'(gpio_out), 64'd0);
        check("rst_dir", 64'(gpio_dir), 64'd0);

        tname = "square100";
        cmd(1, 0, 0, 32'hE081);
        cmd(1, 1, 0, 32'hE101);
        cmd(1, 2, 0, 32'hE000);
        cmd(1, 3, 0, 32'h0001);
        cmd(2, 0, 0, 3);
        cmd(7, 0, 0, 32'h100);
        cmd(5, 0, 0, 1);
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 16; k++) exp_q.push_back(sq(k));
        step(16);
        drain();

        tname = "square280";
        do_reset();
        cmd(2, 0, 0, 3);
        cmd(5, 0, 0, 1);
        cmd(7, 0, 0, 32'h280);
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 25; k++) exp_q.push_back(sq(2 * k / 5));
        step(25);
        drain();
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check("midrst_out", 64'(gpio_out), 64'd0);
        check("midrst_dir", 64'(gpio_dir), 64'd0);
        cmd(2, 0, 0, 3);
        cmd(5, 0, 0, 1);
        repeat (4) @(posedge clk);
        #1 check("midrst_idle_dir", 64'(gpio_dir), 64'd0);

        tname = "mem_kept";
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 12; k++) exp_q.push_back(sq(k));
        step(12);
        drain();

        tname = "xloop";
        do_reset();
        cmd(1, 0, 0, 32'hE023);
        cmd(1, 1, 0, 32'h0041);
        cmd(1, 2, 0, 32'hE001);
        cmd(1, 3, 0, 32'h0003);
        cmd(5, 0, 0, 1);
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 10; k++) exp_q.push_back(k >= 6 ? 64'd1 : 64'd0);
        step(10);
        drain();
        cmd(4, 0, 0, 0);
        check("xloop_x", 64'(dout), RB ? 64'hFFFF_FFFF : 64'd0);

        tname = "wrap";
        do_reset();
        cmd(1, 0, 0, 32'hE001);
        cmd(1, 1, 0, 32'hE002);
        cmd(1, 2, 0, 32'hE003);
        cmd(1, 3, 0, 32'hE004);
        cmd(3, 0, 0, 2);
        cmd(2, 0, 0, 3);
        cmd(5, 0, 0, 3);
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 10; k++) exp_q.push_back(k <= 2 ? 64'(k) : k % 2 == 1 ? 64'd3 : 64'd4);
        step(10);
        drain();
        cmd(6, 0, 0, 0);
        cmd(8, 0, 0, 0);
        check("wrap_pc", 64'(dout), RB ? 64'd2 : 64'd0);

        tname = "conflict";
        do_reset();
        cmd(1, 0, 0, 32'hE002);
        cmd(1, 1, 0, 32'h0001);
        cmd(5, 0, 0, 1);
        cmd(5, 0, 1, 32'h3E2);
        cmd(6, 0, 0, 3);
        for (int k = 0; k < 6; k++) exp_q.push_back(k >= 1 ? 64'd1 : 64'd0);
        step(6);
        drain();

        tname = "ypin";
        do_reset();
        cmd(1, 0, 0, 32'hE042);
        cmd(1, 1, 0, 32'h0081);
        cmd(1, 2, 0, 32'h00C4);
        cmd(1, 3, 0, 32'h0002);
        cmd(1, 4, 0, 32'hE001);
        cmd(1, 5, 0, 32'h0005);
        cmd(5, 0, 0, 32'h1401);
        cmd(6, 0, 0, 1);
        for (int k = 0; k < 14; k++) exp_q.push_back(k >= 10 ? 64'd1 : 64'd0);
        step(8);
        gpio_in = 32'hFFFF_FFFF;
        step(6);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
